ace_snoop_sched: RTL and testbench
==================================

Name: ace_snoop_sched

Overview:
- Sits between an ACE slave port and the CCU, after the shareability decode stage that flags each AW/AR as snooping or non-snooping.
- Steers non-snooping transactions to the bypass path and serialises snooping transactions onto the single snoop engine, with round-robin between AW and AR.
- Enforces ordering between the two paths per direction.
- Control only: it produces handshakes and select signals; payload muxing lives outside.

Parameters:
- MaxTrans, 8: max outstanding bypass transactions per direction (write and read), ≥1.
- CntWidth, $clog2(MaxTrans+1): width of the outstanding counters (derived; do not override).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- slv_aw_valid_i  in  1  AW valid from master
- slv_aw_snoop_i  in  1  AW needs snoop (decode result, stable while valid)
- slv_aw_ready_o  out  1  AW ready to master
- slv_ar_valid_i  in  1  AR valid from master
- slv_ar_snoop_i  in  1  AR needs snoop
- slv_ar_ready_o  out  1  AR ready to master
- byp_aw_valid_o / byp_aw_ready_i  out/in  1  bypass write request handshake
- byp_ar_valid_o / byp_ar_ready_i  out/in  1  bypass read request handshake
- byp_b_done_i  in  1  one-cycle pulse: bypass write fully completed (B handshake)
- byp_r_done_i  in  1  one-cycle pulse: bypass read fully completed (R last handshake)
- snp_valid_o  out  1  request to snoop engine
- snp_is_write_o  out  1  1 = granted AW, 0 = granted AR; selects the payload mux
- snp_ready_i  in  1  snoop engine accepts
- snp_done_i  in  1  one-cycle pulse: snoop transaction completed
- busy_o  out  1  snoop engine occupied (state != IDLE)

Behaviour:
- Reset: FSM = IDLE, rr_q = AW-first, w_cnt_q = r_cnt_q = 0. All valid/ready outputs 0, snp_is_write_o = 0, busy_o = 0.
- Bypass path, per direction (shown for AW; AR is symmetric):
  - Forward only when slv_aw_snoop_i = 0, no snoop of the same direction is granted or in flight, and w_cnt_q < MaxTrans.
  - When forwarding: byp_aw_valid_o = slv_aw_valid_i and slv_aw_ready_o = byp_aw_ready_i. This is a combinational pass-through; valid never depends on ready.
- Counters:
  - +1 on a bypass handshake, -1 on the done pulse; both in the same cycle leaves the count unchanged.
  - At w_cnt_q = MaxTrans, new bypass AWs stall (ready = 0).
  - A done pulse at count 0 is illegal: assertion fires, counter holds at 0 (no wrap).
- FSM states IDLE, REQ, WAIT:
  - IDLE: candidates are AW (valid & snoop & w_cnt_q == 0) and AR (valid & snoop & r_cnt_q == 0).
    - If both are candidates, pick the direction rr_q points to; otherwise pick the single candidate.
    - Latch the direction into dir_q, go to REQ. No request is emitted in IDLE; one cycle minimum to grant.
  - REQ: snp_valid_o = 1, snp_is_write_o = dir_q; the granted slave ready = snp_ready_i.
    - On the handshake: rr_q toggles away from dir_q, go to WAIT.
    - The grant is held until the handshake; dir_q never changes in REQ.
  - WAIT: all snoop-path readies are 0. On snp_done_i, go to IDLE; the next grant is possible the cycle after.
  - snp_done_i outside WAIT is ignored and flagged by assertion.
- Ordering:
  - A snoop is granted only when its direction's bypass counter is 0.
  - Bypass of a direction stalls while a snoop of that direction is in REQ or WAIT.
  - The opposite direction's bypass continues unaffected.
- busy_o = (state != IDLE).
- Reset mid-operation: everything returns to reset values immediately; outstanding bookkeeping is discarded.

Optional Feature:
- Macro ACE_SNOOP_SCHED_STATS_EN.
- Defined: extra output ports stat_snp_w_o [31:0] and stat_snp_r_o [31:0] count accepted snoop handshakes per direction. They reset to 0 and saturate at 32'hFFFF_FFFF.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package ace_sched_pkg holds:
  - the state enum sched_state_e {IDLE, REQ, WAIT};
  - the direction typedef dir_e {DIR_AR = 0, DIR_AW = 1}.
- One natural sub-module: ace_outstanding_cnt, the saturating up/down counter with a full flag. Instantiated twice (write, read).

Test Plan:
- AW snoop=0, byp_aw_ready_i=1, 3 beats back-to-back -> 3 bypass handshakes, w_cnt=3; three byp_b_done_i pulses -> w_cnt=0.
- MaxTrans=2, 3 bypass ARs with no done -> third AR stalls (slv_ar_ready_o=0) until one byp_r_done_i, then accepted next cycle.
- AW snoop=1 and AR snoop=1 both valid from reset -> AW granted first (snp_is_write_o=1). After snp_done_i, AR granted 1 cycle after IDLE re-entry.
- w_cnt=1 outstanding, AW snoop=1 arrives -> no grant until byp_b_done_i. Meanwhile a bypass AR flows freely; snoop granted the cycle after the counter reaches 0.
- Snoop AW in WAIT plus new bypass AW -> slv_aw_ready_o=0 until snp_done_i. Same cycle byp handshake+done -> counter unchanged.
- rst_ni asserted low while in WAIT with w_cnt=2 -> snp_valid_o=0, busy_o=0, counters 0, rr_q AW-first.

Source files
------------

// File: rtl/ace_sched_pkg.sv
// ============================================================================
// ace_sched_pkg : shared types for the ACE snoop scheduler
// Rev 1.0
// ============================================================================
`default_nettype none

package ace_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } sched_state_e;

    typedef enum logic {
        DIR_AR = 1'b0,
        DIR_AW = 1'b1
    } dir_e;

    function automatic dir_e flip_dir(input dir_e d);
        return (d == DIR_AW) ? DIR_AR : DIR_AW;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ace_outstanding_cnt.sv
// ============================================================================
// ace_outstanding_cnt : saturating up/down outstanding-transaction counter
// Rev 1.0
// ============================================================================
`default_nettype none

module ace_outstanding_cnt #(
    parameter  int unsigned MAX_TRANS = 8,
    localparam int unsigned CNT_WIDTH = $clog2(MAX_TRANS + 1)
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic i_inc,
    input  logic i_dec,
    output logic o_full,
    output logic o_zero
);

    localparam logic [CNT_WIDTH-1:0] c_max = CNT_WIDTH'(MAX_TRANS);

    logic [CNT_WIDTH-1:0] r_cnt;

    // Simultaneous inc and dec cancel; a dec at zero is held rather than wrapped.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= '0;
        end else if (i_inc && !i_dec && (r_cnt != c_max)) begin
            r_cnt <= r_cnt + CNT_WIDTH'(1);
        end else if (i_dec && !i_inc && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_WIDTH'(1);
        end
    end

    assign o_full = (r_cnt == c_max);
    assign o_zero = (r_cnt == '0);

    a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(i_dec && !i_inc && (r_cnt == '0)));

endmodule

`default_nettype wire

// File: rtl/ace_snoop_sched.sv
// ============================================================================
// ace_snoop_sched : steers AW/AR to bypass or the single snoop engine (RR)
// Optional stats counters via ACE_SNOOP_SCHED_STATS_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module ace_snoop_sched
    import ace_sched_pkg::*;
#(
    parameter int unsigned MAX_TRANS = 8
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        slv_aw_valid_i,
    input  logic        slv_aw_snoop_i,
    output logic        slv_aw_ready_o,
    input  logic        slv_ar_valid_i,
    input  logic        slv_ar_snoop_i,
    output logic        slv_ar_ready_o,
    output logic        byp_aw_valid_o,
    input  logic        byp_aw_ready_i,
    output logic        byp_ar_valid_o,
    input  logic        byp_ar_ready_i,
    input  logic        byp_b_done_i,
    input  logic        byp_r_done_i,
    output logic        snp_valid_o,
    output logic        snp_is_write_o,
    input  logic        snp_ready_i,
    input  logic        snp_done_i,
    output logic        busy_o
`ifdef ACE_SNOOP_SCHED_STATS_EN
    ,
    output logic [31:0] stat_snp_w_o,
    output logic [31:0] stat_snp_r_o
`endif
);

    sched_state_e r_state, w_state_next;
    dir_e         r_dir, w_dir_next;
    dir_e         r_rr, w_rr_next;

    logic w_w_full, w_w_zero, w_r_full, w_r_zero;
    logic w_snp_aw_busy, w_snp_ar_busy;
    logic w_byp_aw_en, w_byp_ar_en;
    logic w_cand_aw, w_cand_ar;
    logic w_snp_hs;

    // A direction's bypass is frozen while its own snoop is granted or in flight.
    assign w_snp_aw_busy = (r_state != IDLE) && (r_dir == DIR_AW);
    assign w_snp_ar_busy = (r_state != IDLE) && (r_dir == DIR_AR);
    assign w_byp_aw_en   = !slv_aw_snoop_i && !w_snp_aw_busy && !w_w_full;
    assign w_byp_ar_en   = !slv_ar_snoop_i && !w_snp_ar_busy && !w_r_full;
    assign w_cand_aw     = slv_aw_valid_i && slv_aw_snoop_i && w_w_zero;
    assign w_cand_ar     = slv_ar_valid_i && slv_ar_snoop_i && w_r_zero;
    assign w_snp_hs      = (r_state == REQ) && snp_ready_i;

    ace_outstanding_cnt #(.MAX_TRANS(MAX_TRANS)) u_w_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .i_inc  (byp_aw_valid_o && byp_aw_ready_i),
        .i_dec  (byp_b_done_i),
        .o_full (w_w_full),
        .o_zero (w_w_zero)
    );

    ace_outstanding_cnt #(.MAX_TRANS(MAX_TRANS)) u_r_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .i_inc  (byp_ar_valid_o && byp_ar_ready_i),
        .i_dec  (byp_r_done_i),
        .o_full (w_r_full),
        .o_zero (w_r_zero)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
            r_dir   <= DIR_AR;
            r_rr    <= DIR_AW;
        end else begin
            r_state <= w_state_next;
            r_dir   <= w_dir_next;
            r_rr    <= w_rr_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_dir_next   = r_dir;
        w_rr_next    = r_rr;
        case (r_state)
            IDLE: begin
                if (w_cand_aw || w_cand_ar) begin
                    w_state_next = REQ;
                    if (w_cand_aw && w_cand_ar) begin
                        w_dir_next = r_rr;
                    end else begin
                        w_dir_next = w_cand_aw ? DIR_AW : DIR_AR;
                    end
                end
            end
            REQ: begin
                if (snp_ready_i) begin
                    w_state_next = WAIT;
                    w_rr_next    = flip_dir(r_dir);
                end
            end
            WAIT: begin
                if (snp_done_i) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        byp_aw_valid_o = w_byp_aw_en && slv_aw_valid_i;
        byp_ar_valid_o = w_byp_ar_en && slv_ar_valid_i;
        slv_aw_ready_o = w_byp_aw_en && byp_aw_ready_i;
        slv_ar_ready_o = w_byp_ar_en && byp_ar_ready_i;
        snp_valid_o    = 1'b0;
        snp_is_write_o = 1'b0;
        if (r_state == REQ) begin
            snp_valid_o    = 1'b1;
            snp_is_write_o = (r_dir == DIR_AW);
            if (r_dir == DIR_AW) begin
                slv_aw_ready_o = snp_ready_i;
            end else begin
                slv_ar_ready_o = snp_ready_i;
            end
        end
    end

    assign busy_o = (r_state != IDLE);

`ifdef ACE_SNOOP_SCHED_STATS_EN
    logic [31:0] r_stat_w, r_stat_r;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_stat_w <= '0;
            r_stat_r <= '0;
        end else if (w_snp_hs) begin
            if ((r_dir == DIR_AW) && (r_stat_w != 32'hFFFF_FFFF)) begin
                r_stat_w <= r_stat_w + 32'd1;
            end
            if ((r_dir == DIR_AR) && (r_stat_r != 32'hFFFF_FFFF)) begin
                r_stat_r <= r_stat_r + 32'd1;
            end
        end
    end

    assign stat_snp_w_o = r_stat_w;
    assign stat_snp_r_o = r_stat_r;
`endif

    a_done_in_wait: assert property (@(posedge clk_i) disable iff (!rst_ni)
        snp_done_i |-> (r_state == WAIT));

endmodule

`default_nettype wire

// File: tb/tb_ace_snoop_sched.sv
// ============================================================================
// tb_ace_snoop_sched : directed self-checking bench for ace_snoop_sched
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_ace_snoop_sched;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic aw_valid, aw_snoop, ar_valid, ar_snoop;
    logic byp_aw_ready, byp_ar_ready, b_done, r_done, snp_ready, snp_done;
    logic sel_m2;

    logic aw_ready, ar_ready, byp_aw_valid, byp_ar_valid, snp_valid, snp_is_write, busy;
    logic m2_aw_ready, m2_ar_ready, m2_byp_aw_valid, m2_byp_ar_valid;
    logic m2_snp_valid, m2_snp_is_write, m2_busy;
    logic dut_ar_valid, dut_r_done, m2_ar_valid, m2_r_done;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    assign dut_ar_valid = ar_valid && !sel_m2;
    assign dut_r_done   = r_done && !sel_m2;
    assign m2_ar_valid  = ar_valid && sel_m2;
    assign m2_r_done    = r_done && sel_m2;

`ifdef ACE_SNOOP_SCHED_STATS_EN
    logic [31:0] st_w, st_r, m2_st_w, m2_st_r;
`endif

    ace_snoop_sched #(.MAX_TRANS(8)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .slv_aw_valid_i (aw_valid),
        .slv_aw_snoop_i (aw_snoop),
        .slv_aw_ready_o (aw_ready),
        .slv_ar_valid_i (dut_ar_valid),
        .slv_ar_snoop_i (ar_snoop),
        .slv_ar_ready_o (ar_ready),
        .byp_aw_valid_o (byp_aw_valid),
        .byp_aw_ready_i (byp_aw_ready),
        .byp_ar_valid_o (byp_ar_valid),
        .byp_ar_ready_i (byp_ar_ready),
        .byp_b_done_i   (b_done),
        .byp_r_done_i   (dut_r_done),
        .snp_valid_o    (snp_valid),
        .snp_is_write_o (snp_is_write),
        .snp_ready_i    (snp_ready),
        .snp_done_i     (snp_done),
        .busy_o         (busy)
`ifdef ACE_SNOOP_SCHED_STATS_EN
        ,
        .stat_snp_w_o   (st_w),
        .stat_snp_r_o   (st_r)
`endif
    );

    ace_snoop_sched #(.MAX_TRANS(2)) dut_m2 (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .slv_aw_valid_i (1'b0),
        .slv_aw_snoop_i (1'b0),
        .slv_aw_ready_o (m2_aw_ready),
        .slv_ar_valid_i (m2_ar_valid),
        .slv_ar_snoop_i (1'b0),
        .slv_ar_ready_o (m2_ar_ready),
        .byp_aw_valid_o (m2_byp_aw_valid),
        .byp_aw_ready_i (1'b0),
        .byp_ar_valid_o (m2_byp_ar_valid),
        .byp_ar_ready_i (byp_ar_ready),
        .byp_b_done_i   (1'b0),
        .byp_r_done_i   (m2_r_done),
        .snp_valid_o    (m2_snp_valid),
        .snp_is_write_o (m2_snp_is_write),
        .snp_ready_i    (1'b0),
        .snp_done_i     (1'b0),
        .busy_o         (m2_busy)
`ifdef ACE_SNOOP_SCHED_STATS_EN
        ,
        .stat_snp_w_o   (m2_st_w),
        .stat_snp_r_o   (m2_st_r)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        aw_valid = 0; aw_snoop = 0; ar_valid = 0; ar_snoop = 0;
        byp_aw_ready = 0; byp_ar_ready = 0; b_done = 0; r_done = 0;
        snp_ready = 0; snp_done = 0; sel_m2 = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 0;
        #2;
        rst_n = 1;
        tick();
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 0;
        repeat (2) tick();
        n_total++; if (snp_valid !== 1'b0) $display("FAIL reset_snp_valid: got %b exp 0", snp_valid); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b exp 0", busy); else n_pass++;
        n_total++; if (snp_is_write !== 1'b0) $display("FAIL reset_is_write: got %b exp 0", snp_is_write); else n_pass++;
        n_total++; if ({aw_ready, ar_ready, byp_aw_valid, byp_ar_valid} !== 4'b0000)
            $display("FAIL reset_handshakes: got %b exp 0000", {aw_ready, ar_ready, byp_aw_valid, byp_ar_valid}); else n_pass++;
        n_total++; if (dut.u_w_cnt.r_cnt !== 4'd0) $display("FAIL reset_wcnt: got %0d exp 0", dut.u_w_cnt.r_cnt); else n_pass++;
        rst_n = 1;
        tick();
    endtask

    task automatic test_bypass_aw();
        aw_valid = 1; aw_snoop = 0; byp_aw_ready = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_total++; if ({byp_aw_valid, aw_ready} !== 2'b11)
                $display("FAIL byp_aw_beat%0d: got %b exp 11", i, {byp_aw_valid, aw_ready}); else n_pass++;
            tick();
        end
        aw_valid = 0; byp_aw_ready = 0;
        #1;
        n_total++; if (dut.u_w_cnt.r_cnt !== 4'd3) $display("FAIL byp_aw_cnt3: got %0d exp 3", dut.u_w_cnt.r_cnt); else n_pass++;
        b_done = 1;
        repeat (3) tick();
        b_done = 0;
        #1;
        n_total++; if (dut.u_w_cnt.r_cnt !== 4'd0) $display("FAIL byp_aw_drain: got %0d exp 0", dut.u_w_cnt.r_cnt); else n_pass++;
    endtask

    task automatic test_ar_stall();
        sel_m2 = 1; ar_valid = 1; ar_snoop = 0; byp_ar_ready = 1;
        #1;
        n_total++; if (m2_ar_ready !== 1'b1) $display("FAIL stall_ar0: got %b exp 1", m2_ar_ready); else n_pass++;
        tick();
        n_total++; if (m2_ar_ready !== 1'b1) $display("FAIL stall_ar1: got %b exp 1", m2_ar_ready); else n_pass++;
        tick();
        n_total++; if ({m2_ar_ready, m2_byp_ar_valid} !== 2'b00)
            $display("FAIL stall_ar2_full: got %b exp 00", {m2_ar_ready, m2_byp_ar_valid}); else n_pass++;
        tick();
        r_done = 1;
        #1;
        n_total++; if (m2_ar_ready !== 1'b0) $display("FAIL stall_ar_done_cycle: got %b exp 0", m2_ar_ready); else n_pass++;
        tick();
        r_done = 0;
        #1;
        n_total++; if (m2_ar_ready !== 1'b1) $display("FAIL stall_ar_resume: got %b exp 1", m2_ar_ready); else n_pass++;
        tick();
        ar_valid = 0; byp_ar_ready = 0;
        #1;
        n_total++; if (dut_m2.u_r_cnt.r_cnt !== 2'd2) $display("FAIL stall_ar_cnt: got %0d exp 2", dut_m2.u_r_cnt.r_cnt); else n_pass++;
        r_done = 1;
        repeat (2) tick();
        r_done = 0; sel_m2 = 0;
        #1;
        n_total++; if (dut_m2.u_r_cnt.r_cnt !== 2'd0) $display("FAIL stall_ar_drain: got %0d exp 0", dut_m2.u_r_cnt.r_cnt); else n_pass++;
    endtask

    task automatic test_snoop_rr();
        do_reset();
        aw_valid = 1; aw_snoop = 1; ar_valid = 1; ar_snoop = 1;
        #1;
        n_total++; if ({snp_valid, busy, aw_ready} !== 3'b000)
            $display("FAIL rr_idle_no_req: got %b exp 000", {snp_valid, busy, aw_ready}); else n_pass++;
        tick();
        n_total++; if ({snp_valid, snp_is_write, busy} !== 3'b111)
            $display("FAIL rr_aw_first: got %b exp 111", {snp_valid, snp_is_write, busy}); else n_pass++;
        n_total++; if (aw_ready !== 1'b0) $display("FAIL rr_aw_hold: got %b exp 0", aw_ready); else n_pass++;
        snp_ready = 1;
        #1;
        n_total++; if ({aw_ready, ar_ready} !== 2'b10) $display("FAIL rr_aw_ready: got %b exp 10", {aw_ready, ar_ready}); else n_pass++;
        tick();
        aw_valid = 0; aw_snoop = 0; snp_ready = 0;
        #1;
        n_total++; if ({snp_valid, busy} !== 2'b01) $display("FAIL rr_wait: got %b exp 01", {snp_valid, busy}); else n_pass++;
        tick();
        snp_done = 1;
        tick();
        snp_done = 0;
        #1;
        n_total++; if ({snp_valid, busy} !== 2'b00) $display("FAIL rr_idle_reentry: got %b exp 00", {snp_valid, busy}); else n_pass++;
        tick();
        n_total++; if ({snp_valid, snp_is_write} !== 2'b10) $display("FAIL rr_ar_second: got %b exp 10", {snp_valid, snp_is_write}); else n_pass++;
        snp_ready = 1;
        #1;
        n_total++; if ({aw_ready, ar_ready} !== 2'b01) $display("FAIL rr_ar_ready: got %b exp 01", {aw_ready, ar_ready}); else n_pass++;
        tick();
        ar_valid = 0; ar_snoop = 0; snp_ready = 0;
        snp_done = 1;
        tick();
        snp_done = 0;
        #1;
        n_total++; if (busy !== 1'b0) $display("FAIL rr_final_idle: got %b exp 0", busy); else n_pass++;
    endtask

    task automatic test_order();
        aw_valid = 1; aw_snoop = 0; byp_aw_ready = 1;
        tick();
        aw_snoop = 1; byp_aw_ready = 0;
        ar_valid = 1; ar_snoop = 0; byp_ar_ready = 1;
        #1;
        n_total++; if ({ar_ready, byp_ar_valid, aw_ready, busy} !== 4'b1100)
            $display("FAIL order_ar_flows: got %b exp 1100", {ar_ready, byp_ar_valid, aw_ready, busy}); else n_pass++;
        tick();
        ar_valid = 0; byp_ar_ready = 0;
        #1;
        n_total++; if ({snp_valid, busy} !== 2'b00) $display("FAIL order_blocked: got %b exp 00", {snp_valid, busy}); else n_pass++;
        b_done = 1;
        tick();
        b_done = 0;
        #1;
        n_total++; if ({snp_valid, busy} !== 2'b00) $display("FAIL order_cnt0_cycle: got %b exp 00", {snp_valid, busy}); else n_pass++;
        tick();
        n_total++; if ({snp_valid, snp_is_write} !== 2'b11) $display("FAIL order_grant: got %b exp 11", {snp_valid, snp_is_write}); else n_pass++;
        snp_ready = 1;
        tick();
        snp_ready = 0; aw_valid = 0; aw_snoop = 0;
    endtask

    task automatic test_wait_stall();
        aw_valid = 1; aw_snoop = 0; byp_aw_ready = 1;
        ar_valid = 1; ar_snoop = 0; byp_ar_ready = 1; r_done = 1;
        #1;
        n_total++; if ({aw_ready, byp_aw_valid, ar_ready, busy} !== 4'b0011)
            $display("FAIL wait_aw_stall: got %b exp 0011", {aw_ready, byp_aw_valid, ar_ready, busy}); else n_pass++;
        tick();
        ar_valid = 0; r_done = 0; byp_ar_ready = 0;
        #1;
        n_total++; if (dut.u_r_cnt.r_cnt !== 4'd1) $display("FAIL wait_r_inc_dec: got %0d exp 1", dut.u_r_cnt.r_cnt); else n_pass++;
        snp_done = 1;
        #1;
        n_total++; if (aw_ready !== 1'b0) $display("FAIL wait_done_cycle: got %b exp 0", aw_ready); else n_pass++;
        tick();
        snp_done = 0;
        #1;
        n_total++; if ({busy, aw_ready, byp_aw_valid} !== 3'b011)
            $display("FAIL wait_aw_release: got %b exp 011", {busy, aw_ready, byp_aw_valid}); else n_pass++;
        tick();
        b_done = 1;
        tick();
        aw_valid = 0; b_done = 0; byp_aw_ready = 0;
        #1;
        n_total++; if (dut.u_w_cnt.r_cnt !== 4'd1) $display("FAIL wait_w_inc_dec: got %0d exp 1", dut.u_w_cnt.r_cnt); else n_pass++;
        b_done = 1; r_done = 1;
        tick();
        b_done = 0; r_done = 0;
        #1;
        n_total++; if ({dut.u_w_cnt.r_cnt, dut.u_r_cnt.r_cnt} !== 8'h00)
            $display("FAIL wait_drain: got %h exp 00", {dut.u_w_cnt.r_cnt, dut.u_r_cnt.r_cnt}); else n_pass++;
    endtask

    task automatic test_reset_mid();
        aw_valid = 1; aw_snoop = 0; byp_aw_ready = 1;
        repeat (2) tick();
        aw_valid = 0; byp_aw_ready = 0;
        ar_valid = 1; ar_snoop = 1;
        tick();
        snp_ready = 1;
        tick();
        ar_valid = 0; ar_snoop = 0; snp_ready = 0;
        #1;
        n_total++; if ({busy, dut.u_w_cnt.r_cnt} !== 5'b1_0010)
            $display("FAIL mid_setup: got %b exp 10010", {busy, dut.u_w_cnt.r_cnt}); else n_pass++;
        rst_n = 0;
        #1;
        n_total++; if ({snp_valid, busy} !== 2'b00) $display("FAIL mid_rst_outputs: got %b exp 00", {snp_valid, busy}); else n_pass++;
        n_total++; if ({dut.u_w_cnt.r_cnt, dut.u_r_cnt.r_cnt} !== 8'h00)
            $display("FAIL mid_rst_cnts: got %h exp 00", {dut.u_w_cnt.r_cnt, dut.u_r_cnt.r_cnt}); else n_pass++;
        n_total++; if (dut.r_rr !== 1'b1) $display("FAIL mid_rst_rr: got %b exp 1", dut.r_rr); else n_pass++;
        tick();
        rst_n = 1;
        aw_valid = 1; aw_snoop = 1; ar_valid = 1; ar_snoop = 1;
        tick();
        n_total++; if ({snp_valid, snp_is_write} !== 2'b11) $display("FAIL mid_rst_aw_first: got %b exp 11", {snp_valid, snp_is_write}); else n_pass++;
        clear_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout exp completion");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        test_reset();
        test_bypass_aw();
        test_ar_stall();
        test_snoop_rr();
        test_order();
        test_wait_stall();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
